// File: rtl/fsm_test_pkg.sv
// Shared types and helpers for the FSM stimulus sequencer and its output checker.
package fsm_test_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned VEC_W   = 8;

  // Sequencer states. The codes are visible on first_err_step, so keep them fixed.
  typedef enum logic [STATE_W-1:0] {
    StIdle  = 3'd0,
    StRel   = 3'd1,
    StA     = 3'd2,
    StGap   = 3'd3,
    StB     = 3'd4,
    StF     = 3'd5,
    StG     = 3'd6,
    StDrain = 3'd7
  } seq_state_e;

  // Signals driven into both FSMs under test.
  typedef struct packed {
    logic dut_rstn;
    logic a;
    logic b;
    logic f;
    logic g;
  } drive_t;

  // Drive pattern that belongs to each state.
  function automatic drive_t drive_of(input seq_state_e s);
    drive_t d;
    d = '0;
    case (s)
      StIdle: d = '0;
      StRel: d.dut_rstn = 1'b1;
      StA: begin
        d.dut_rstn = 1'b1;
        d.a        = 1'b1;
      end
      StGap: d.dut_rstn = 1'b1;
      StB: begin
        d.dut_rstn = 1'b1;
        d.b        = 1'b1;
      end
      StF: begin
        d.dut_rstn = 1'b1;
        d.f        = 1'b1;
      end
      StG: begin
        d.dut_rstn = 1'b1;
        d.f        = 1'b1;
        d.g        = 1'b1;
      end
      StDrain: begin
        // FSMs back in reset while f/g stay up, so they are not compared here.
        d.f = 1'b1;
        d.g = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  // Fixed step order of the canonical sequence.
  function automatic seq_state_e next_step(input seq_state_e s);
    seq_state_e n;
    case (s)
      StRel:   n = StA;
      StA:     n = StGap;
      StGap:   n = StB;
      StB:     n = StF;
      StF:     n = StG;
      StG:     n = StDrain;
      StDrain: n = StIdle;
      default: n = StIdle;
    endcase
    return n;
  endfunction

  // States whose FSM outputs are worth comparing (FSMs out of reset).
  function automatic logic in_cmp_window(input seq_state_e s);
    return (s != StIdle) && (s != StDrain);
  endfunction

endpackage

// File: rtl/fsm_out_cmp.sv
// Lock-step comparator: registers the two FSM output nibbles with the state that
// drove them, counts differing cycles (saturating) and captures the first failure.
module fsm_out_cmp
  import fsm_test_pkg::*;
#(
  parameter int unsigned CntW = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  seq_state_e         state_i,
  input  logic [VEC_W-1:0]   vec_i,
  output logic [CntW-1:0]    mismatch_cnt_o,
  output logic [STATE_W-1:0] first_err_step_o,
  output logic [VEC_W-1:0]   first_err_vec_o,
  output logic               err_o
);

  localparam int unsigned Half = VEC_W / 2;

  seq_state_e         tag_q;
  logic [VEC_W-1:0]   vec_q;
  logic [CntW-1:0]    cnt_q;
  logic [STATE_W-1:0] step_q;
  logic [VEC_W-1:0]   fvec_q;
  logic               err_q;
  logic               hit;

  // A mismatch is any differing bit between the two instances in a compared state.
  always_comb begin
    hit = in_cmp_window(tag_q) && (vec_q[VEC_W-1:Half] != vec_q[Half-1:0]);
  end

  // Sample stage plus result registers; a new run clears results before counting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q  <= StIdle;
      vec_q  <= '0;
      cnt_q  <= '0;
      step_q <= '0;
      fvec_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tag_q <= state_i;
      vec_q <= vec_i;
      if (clear_i) begin
        cnt_q  <= '0;
        step_q <= '0;
        fvec_q <= '0;
        err_q  <= 1'b0;
      end else if (hit) begin
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + CntW'(1);
        end
        if (cnt_q == '0) begin
          step_q <= tag_q;
          fvec_q <= vec_q;
        end
        err_q <= 1'b1;
      end
    end
  end

  assign mismatch_cnt_o   = cnt_q;
  assign first_err_step_o = step_q;
  assign first_err_vec_o  = fvec_q;
  assign err_o            = err_q;

endmodule

// File: rtl/fsm_stim_seq.sv
// Stimulus sequencer for two FSM instances: plays the canonical a/b/f/g sequence,
// releases their reset, and checks their outputs against each other every cycle.
module fsm_stim_seq
  import fsm_test_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  output logic               dut_rstn,
  output logic               a,
  output logic               b,
  output logic               f,
  output logic               g,
  input  logic               c0,
  input  logic               d0,
  input  logic               e0,
  input  logic               h0,
  input  logic               c1,
  input  logic               d1,
  input  logic               e1,
  input  logic               h1,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [STATE_W-1:0] first_err_step,
  output logic [VEC_W-1:0]   first_err_vec,
  output logic               err
);

  localparam logic [7:0] LastCnt = 8'(STEP_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       accept;
  drive_t     drive_q, drive_d;
  logic       busy_q, done_q;

  // Next state and step counter; the counter restarts on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    accept  = 1'b0;
    if (state_q == StIdle) begin
      cnt_d = '0;
      if (start) begin
        state_d = StRel;
        accept  = 1'b1;
      end
    end else if (cnt_q == LastCnt) begin
      state_d = next_step(state_q);
      cnt_d   = '0;
    end
    drive_d = drive_of(state_d);
  end

  // Sequencer FSM with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drive_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drive_q <= drive_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_q == StDrain) && (state_d == StIdle);
    end
  end

  assign dut_rstn = drive_q.dut_rstn;
  assign a        = drive_q.a;
  assign b        = drive_q.b;
  assign f        = drive_q.f;
  assign g        = drive_q.g;
  assign busy     = busy_q;
  assign done     = done_q;

  fsm_out_cmp #(
    .CntW(CNT_W)
  ) u_cmp (
    .clk_i           (clk),
    .rst_i           (rstn),
    .clear_i         (accept),
    .state_i         (state_q),
    .vec_i           ({c0, d0, e0, h0, c1, d1, e1, h1}),
    .mismatch_cnt_o  (mismatch_cnt),
    .first_err_step_o(first_err_step),
    .first_err_vec_o (first_err_vec),
    .err_o           (err)
  );

endmodule

// File: tb/tb_fsm_stim_seq.sv
// Bench for fsm_stim_seq: two sequencer instances (wide and 2-bit counters) watch
// a pair of trivial stand-in FSMs whose second copy can be made to diverge.
module tb_fsm_stim_seq;

  localparam int STEP = 3;
  localparam int RUN_LEN = 7 * STEP;

  logic clk = 1'b0;
  logic rstn, start;
  logic [1:0] mode;

  logic dut_rstn, a, b, f, g, busy, done, err;
  logic [7:0] mismatch_cnt;
  logic [2:0] first_err_step;
  logic [7:0] first_err_vec;

  logic s_dut_rstn, s_a, s_b, s_f, s_g, s_busy, s_done, s_err;
  logic [1:0] s_cnt;
  logic [2:0] s_step;
  logic [7:0] s_vec;

  logic c0, d0, e0, h0, c1, d1, e1, h1;

  int checks = 0;
  int errors = 0;

  // Stand-in FSMs: instance 1 copies instance 0 except h, which mode can corrupt.
  assign c0 = a;
  assign d0 = b;
  assign e0 = f;
  assign h0 = g & dut_rstn;
  assign c1 = c0;
  assign d1 = d0;
  assign e1 = e0;
  assign h1 = h0 ^ ((mode == 2'd1) ? b : (mode == 2'd2));

  always #5 clk = ~clk;

  fsm_stim_seq #(.STEP_CYCLES(STEP), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .dut_rstn(dut_rstn),
    .a(a), .b(b), .f(f), .g(g),
    .c0(c0), .d0(d0), .e0(e0), .h0(h0), .c1(c1), .d1(d1), .e1(e1), .h1(h1),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt),
    .first_err_step(first_err_step), .first_err_vec(first_err_vec), .err(err)
  );

  fsm_stim_seq #(.STEP_CYCLES(STEP), .CNT_W(2)) dut_sat (
    .clk(clk), .rstn(rstn), .start(start), .dut_rstn(s_dut_rstn),
    .a(s_a), .b(s_b), .f(s_f), .g(s_g),
    .c0(c0), .d0(d0), .e0(e0), .h0(h0), .c1(c1), .d1(d1), .e1(e1), .h1(h1),
    .busy(s_busy), .done(s_done), .mismatch_cnt(s_cnt),
    .first_err_step(s_step), .first_err_vec(s_vec), .err(s_err)
  );

  typedef struct {
    logic [1:0] mode;
    int         exp_cnt;
    int         exp_sat;
    logic [2:0] exp_step;
    logic [7:0] exp_vec;
    logic       exp_err;
    int         extra_start;
  } run_vec_t;

  run_vec_t runs[4];
  logic [6:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {dut_rstn,a,b,f,g,busy,done} k cycles after the accepting edge.
  function automatic logic [6:0] model_drive(input int k);
    case (k / STEP)
      0: return 7'b1000010;
      1: return 7'b1100010;
      2: return 7'b1000010;
      3: return 7'b1010010;
      4: return 7'b1001010;
      5: return 7'b1001110;
      6: return 7'b0001110;
      default: return 7'b0000001;
    endcase
  endfunction

  task automatic run_seq(input run_vec_t v, input bit chained, input bit chain_out);
    logic [6:0] exp;
    mode = v.mode;
    if (!chained) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int k = 0; k <= RUN_LEN; k++) exp_q.push_back(model_drive(k));
    for (int k = 0; k <= RUN_LEN; k++) begin
      @(posedge clk);
      #1;
      start = (k == v.extra_start);
      exp = exp_q.pop_front();
      chk("drive", {25'd0, dut_rstn, a, b, f, g, busy, done}, {25'd0, exp});
      chk("sat_drive", {25'd0, s_dut_rstn, s_a, s_b, s_f, s_g, s_busy, s_done}, {25'd0, exp});
      if (k == 0) begin
        chk("clr_cnt", {24'd0, mismatch_cnt}, 0);
        chk("clr_err", {31'd0, err}, 0);
        chk("clr_step_vec", {21'd0, first_err_step, first_err_vec}, 0);
        chk("clr_sat_cnt", {30'd0, s_cnt}, 0);
      end
      if (k == RUN_LEN) begin
        chk("cnt", {24'd0, mismatch_cnt}, v.exp_cnt);
        chk("step", {29'd0, first_err_step}, {29'd0, v.exp_step});
        chk("vec", {24'd0, first_err_vec}, {24'd0, v.exp_vec});
        chk("err", {31'd0, err}, {31'd0, v.exp_err});
        chk("sat_cnt", {30'd0, s_cnt}, v.exp_sat);
        chk("sat_step", {29'd0, s_step}, {29'd0, v.exp_step});
        chk("sat_vec", {24'd0, s_vec}, {24'd0, v.exp_vec});
        chk("sat_err", {31'd0, s_err}, {31'd0, v.exp_err});
        if (chain_out) start = 1'b1;
      end
    end
  endtask

  task automatic chk_reset_state(input string name);
    chk(name, {dut_rstn, a, b, f, g, busy, done, err, mismatch_cnt, first_err_step,
               first_err_vec}, 0);
    chk({name, "_sat"}, {s_dut_rstn, s_a, s_b, s_f, s_g, s_busy, s_done, s_err, s_cnt,
                         s_step, s_vec}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    runs[0] = '{mode: 2'd0, exp_cnt: 0,  exp_sat: 0, exp_step: 3'd0, exp_vec: 8'h00,
                exp_err: 1'b0, extra_start: -1};
    runs[1] = '{mode: 2'd1, exp_cnt: 3,  exp_sat: 3, exp_step: 3'd4, exp_vec: 8'h45,
                exp_err: 1'b1, extra_start: -1};
    runs[2] = '{mode: 2'd2, exp_cnt: 18, exp_sat: 3, exp_step: 3'd1, exp_vec: 8'h01,
                exp_err: 1'b1, extra_start: -1};
    runs[3] = '{mode: 2'd0, exp_cnt: 0,  exp_sat: 0, exp_step: 3'd0, exp_vec: 8'h00,
                exp_err: 1'b0, extra_start: 4};

    // Reset, then idle with no start.
    mode  = 2'd0;
    start = 1'b0;
    rstn  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_reset_state("idle");
    end

    // Table of full runs; the last one pulses start again while in A.
    foreach (runs[i]) run_seq(runs[i], 1'b0, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      bad = bad | busy | done | s_busy | s_done;
    end
    chk("no_requeued_start", {31'd0, bad}, 0);

    // Start coincident with done: second run begins straight away with cleared results.
    run_seq(runs[1], 1'b0, 1'b1);
    run_seq(runs[0], 1'b1, 1'b0);

    // Reset in the middle of state F.
    mode = 2'd2;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("midrun_in_f", {31'd0, f}, 1);
    chk("midrun_cnt_nonzero", {31'd0, (mismatch_cnt != 8'd0)}, 1);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state("midrun_reset");
    rstn = 1'b0;
    bad  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      bad = bad | busy | done | s_busy | s_done | err;
    end
    chk("no_done_after_reset", {31'd0, bad}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
